// File: rtl/result_demux3.sv
// Registered 1-to-3 steering block: routes a valid/ready result stream to one of
// three one-entry holding slots selected by {sel1,sel2}; select 11 is dropped and counted.
module result_demux3 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  input  logic             err_clr,
  output logic             err_sel,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [1:0] SEL_ILLEGAL = 2'b11;

  logic [1:0]       w_sel;
  logic             w_illegal;
  logic [2:0]       w_oready;
  logic [2:0]       w_free;
  logic [2:0]       w_load;
  logic [2:0]       w_drain;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_drop;

  logic [2:0]       r_valid;
  logic [WIDTH-1:0] r_data [3];
  logic             r_err_sel;
  logic [CNT_W-1:0] r_drop_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_sel     = {sel1, sel2};
  assign w_illegal = (w_sel == SEL_ILLEGAL);
  assign w_oready  = {out3_ready, out2_ready, out1_ready};
  // A slot can take a beat if empty or being drained on this same edge.
  assign w_free    = ~r_valid | w_oready;
  assign w_drain   = r_valid & w_oready;

  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      case (w_sel)
        2'b00:   w_in_ready = w_free[0];
        2'b01:   w_in_ready = w_free[1];
        2'b10:   w_in_ready = w_free[2];
        default: w_in_ready = 1'b1;
      endcase
    end
  end

  assign w_accept = in_valid && w_in_ready;
  assign w_drop   = w_accept && w_illegal;

  always_comb begin
    w_load = '0;
    if (w_accept && !w_illegal) begin
      case (w_sel)
        2'b00:   w_load[0] = 1'b1;
        2'b01:   w_load[1] = 1'b1;
        default: w_load[2] = 1'b1;
      endcase
    end
  end

  // Slot registers: load wins over drain so a slot can refill every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < 3; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_load[i]) begin
          r_data[i]  <= in_data;
          r_valid[i] <= 1'b1;
        end else if (w_drain[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Illegal-select bookkeeping: a new drop takes precedence over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sel  <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_err_sel  <= 1'b1;
      r_drop_cnt <= err_clr ? CNT_W'(1) : sat_inc(r_drop_cnt);
    end else if (err_clr) begin
      r_err_sel  <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out1_data  = r_data[0];
  assign out2_data  = r_data[1];
  assign out3_data  = r_data[2];
  assign out1_valid = r_valid[0];
  assign out2_valid = r_valid[1];
  assign out3_valid = r_valid[2];
  assign err_sel    = r_err_sel;
  assign drop_cnt   = r_drop_cnt;

endmodule
